// File: rtl/fir4_inverse_seq_pkg.sv
// FSM encoding and tap sequencing for fir4_inverse_seq.
package fir4_inverse_seq_pkg;

    typedef enum logic [2:0] {IDLE, MAC1, MAC2, MAC3, OUT} state_t;

    // History tap consumed by the multiplier in each MAC state.
    function automatic logic [1:0] tap_of(input state_t s);
        case (s)
            MAC1:    return 2'd1;
            MAC2:    return 2'd2;
            default: return 2'd3;
        endcase
    endfunction

endpackage

// File: rtl/weight_pkg.sv
// Shared coefficient package for the fir_4 transmit filter and its inverse.
// w0 must be a power of two (1 << W0_SHIFT) so the inverse divides by shifting.
package weight_pkg;

    typedef logic signed [7:0]  sample_t;
    typedef logic signed [17:0] fir_out_t;
    typedef logic signed [19:0] fir_acc_t;

    localparam int W0_SHIFT = 0;

    localparam sample_t weight_0 = 8'sd1;
    localparam sample_t weight_1 = 8'sd2;
    localparam sample_t weight_2 = -8'sd3;
    localparam sample_t weight_3 = 8'sd4;

    // Coefficient for history tap k (k = 1..3).
    function automatic sample_t weight_sel(input logic [1:0] k);
        case (k)
            2'd1:    return weight_1;
            2'd2:    return weight_2;
            2'd3:    return weight_3;
            default: return '0;
        endcase
    endfunction

endpackage

// File: rtl/fir4_inverse_seq_if.sv
// Handshake bundle for fir4_inverse_seq: y_in stream in, x_out/err stream out.
interface fir4_inverse_seq_if #(
    parameter int X_W = 8,
    parameter int Y_W = 18
);
    logic                  in_valid;
    logic                  in_ready;
    logic signed [Y_W-1:0] y_in;
    logic                  out_valid;
    logic                  out_ready;
    logic signed [X_W-1:0] x_out;
    logic                  err;

    modport master (
        output in_valid, y_in, out_ready,
        input  in_ready, out_valid, x_out, err
    );

    modport slave (
        input  in_valid, y_in, out_ready,
        output in_ready, out_valid, x_out, err
    );
endinterface

// File: rtl/fir4_inverse_seq_hist.sv
// fir_inv_hist: three-deep history of recovered samples plus the shared
// multiplier operand mux (history tap and matching coefficient).
module fir_inv_hist
    import weight_pkg::*;
    import fir4_inverse_seq_pkg::*;
#(
    parameter int X_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  shift_en,
    input  logic signed [X_W-1:0] din,
    input  logic [1:0]            tap_sel_i,
    output logic signed [X_W-1:0] tap_x_o,
    output sample_t               tap_w_o
);

    logic signed [X_W-1:0] x1_q, x2_q, x3_q;

    // History shift register, advanced once per recovered sample.
    always_ff @(posedge clk) begin
        if (rst) begin
            x1_q <= '0;
            x2_q <= '0;
            x3_q <= '0;
        end else if (shift_en) begin
            x3_q <= x2_q;
            x2_q <= x1_q;
            x1_q <= din;
        end
    end

    // Operand mux feeding the single multiplier.
    always_comb begin
        case (tap_sel_i)
            2'd1:    tap_x_o = x1_q;
            2'd2:    tap_x_o = x2_q;
            default: tap_x_o = x3_q;
        endcase
        tap_w_o = weight_sel(tap_sel_i);
    end

endmodule

// File: rtl/fir4_inverse_seq.sv
// fir4_inverse_seq: sequential inverse of the 4-tap FIR, one multiplier,
// x[n] = (y[n] - w1*x[n-1] - w2*x[n-2] - w3*x[n-3]) >>> W0_SHIFT.
// Optional macro FIR_INV_SAT_EN: saturate the result and flag clamp/inexact on err.
module fir4_inverse_seq
    import weight_pkg::*;
    import fir4_inverse_seq_pkg::*;
#(
    parameter int X_W   = 8,
    parameter int Y_W   = 18,
    parameter int ACC_W = 20
) (
    input  logic              clk,
    input  logic              rst,
    fir4_inverse_seq_if.slave bus
);

    localparam int PW = X_W + $bits(sample_t);
    localparam logic signed [ACC_W-1:0] XMAX = ACC_W'((1 << (X_W - 1)) - 1);
    localparam logic signed [ACC_W-1:0] XMIN = ~XMAX;

    if (weight_0 != sample_t'(1 << W0_SHIFT)) begin : g_w0_check
        $error("weight_0 must equal 1 << W0_SHIFT");
    end

    state_t                  state_q, state_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic signed [X_W-1:0]   x_out_q, x_out_d;
    logic                    err_q, err_d;

    logic [1:0]              tap_sel;
    logic                    shift_en;
    logic signed [X_W-1:0]   tap_x;
    sample_t                 tap_w;
    logic signed [PW-1:0]    prod;
    logic signed [ACC_W-1:0] prod_ext, acc_fin, r;
    logic [ACC_W-1:0]        low_mask;
    logic                    inexact;
    logic signed [X_W-1:0]   x_val;
    logic                    err_val;

    fir_inv_hist #(.X_W(X_W)) u_hist (
        .clk       (clk),
        .rst       (rst),
        .shift_en  (shift_en),
        .din       (x_val),
        .tap_sel_i (tap_sel),
        .tap_x_o   (tap_x),
        .tap_w_o   (tap_w)
    );

    assign prod     = tap_x * tap_w;
    assign prod_ext = {{(ACC_W - PW){prod[PW-1]}}, prod};
    assign acc_fin  = acc_q - prod_ext;
    assign r        = acc_fin >>> W0_SHIFT;
    assign low_mask = ACC_W'((1 << W0_SHIFT) - 1);
    assign inexact  = |(acc_fin & low_mask);

`ifdef FIR_INV_SAT_EN
    // Clamp to the sample range; err reports a clamp or a lossy shift.
    always_comb begin
        x_val   = r[X_W-1:0];
        err_val = inexact;
        if (r > XMAX) begin
            x_val   = XMAX[X_W-1:0];
            err_val = 1'b1;
        end else if (r < XMIN) begin
            x_val   = XMIN[X_W-1:0];
            err_val = 1'b1;
        end
    end
`else
    logic unused_bits;
    assign unused_bits = ^{r[ACC_W-1:X_W], inexact, XMIN, XMAX};

    // Two's-complement wrap; err never raised.
    always_comb begin
        x_val   = r[X_W-1:0];
        err_val = 1'b0;
    end
`endif

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            x_out_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            x_out_q <= x_out_d;
            err_q   <= err_d;
        end
    end

    // Next-state and datapath next values.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        x_out_d = x_out_q;
        err_d   = err_q;
        case (state_q)
            IDLE: if (bus.in_valid) begin
                acc_d   = {{(ACC_W - Y_W){bus.y_in[Y_W-1]}}, bus.y_in};
                state_d = MAC1;
            end
            MAC1: begin
                acc_d   = acc_fin;
                state_d = MAC2;
            end
            MAC2: begin
                acc_d   = acc_fin;
                state_d = MAC3;
            end
            MAC3: begin
                acc_d   = acc_fin;
                x_out_d = x_val;
                err_d   = err_val;
                state_d = OUT;
            end
            OUT: if (bus.out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Moore outputs decoded from the current state.
    always_comb begin
        bus.in_ready  = (state_q == IDLE);
        bus.out_valid = (state_q == OUT);
        tap_sel       = tap_of(state_q);
        shift_en      = (state_q == MAC3);
    end

    assign bus.x_out = x_out_q;
    assign bus.err   = err_q;

endmodule

// File: tb/tb_fir4_inverse_seq.sv
// Scoreboard bench for fir4_inverse_seq (weights 1, 2, -3, 4; W0_SHIFT = 0).
module tb_fir4_inverse_seq;

    typedef struct {
        logic signed [7:0] x;
        logic              e;
        int                hs;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;
    int   rx = 0;
    int   last_hs = -1;
    int   gap = 0;
    exp_t q[$];

    fir4_inverse_seq_if bus_if ();

    fir4_inverse_seq #(.X_W(8), .Y_W(18), .ACC_W(20)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Monitor: pops the scoreboard on every accepted output.
    initial begin
        bit   prev_v = 1'b0;
        int   rise_cyc = 0;
        exp_t e;
        forever begin
            @(negedge clk);
            #1;
            if (bus_if.out_valid && !prev_v) rise_cyc = cyc;
            prev_v = bus_if.out_valid;
            if (bus_if.out_valid && bus_if.out_ready) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output actual=%0d required=none", bus_if.x_out);
                end else begin
                    e = q.pop_front();
                    chk("x_out", bus_if.x_out, e.x);
                    chk("err", bus_if.err, e.e);
                    chk("latency", rise_cyc - e.hs, 4);
                    rx++;
                end
            end
        end
    end

    // Present one sample; called and returns at a falling edge.
    task automatic send(input int y, input int ex, input bit ee, input bit push);
        int n = 0;
        bus_if.y_in     = 18'(y);
        bus_if.in_valid = 1'b1;
        while (!bus_if.in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!bus_if.in_ready) begin
            chk("in_handshake_timeout", 0, 1);
            bus_if.in_valid = 1'b0;
            return;
        end
        if (push) q.push_back('{x: 8'(ex), e: ee, hs: cyc});
        gap     = cyc - last_hs;
        last_hs = cyc;
        @(negedge clk);
        bus_if.in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("drain", q.size(), 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int xs[20];
        int ys[20];
        int rx0;
        int n;

        bus_if.in_valid  = 1'b0;
        bus_if.out_ready = 1'b1;
        bus_if.y_in      = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_in_ready", bus_if.in_ready, 1);
        chk("rst_out_valid", bus_if.out_valid, 0);
        chk("rst_x_out", bus_if.x_out, 0);
        chk("rst_err", bus_if.err, 0);

        // Impulse recovery
        send(10, 10, 0, 1);
        send(20, 0, 0, 1);
        send(-30, 0, 0, 1);
        send(40, 0, 0, 1);
        drain();

        // Steady state: fir_4 of 3,5,2,1 is 3,11,3,2
        send(3, 3, 0, 1);
        send(11, 5, 0, 1);
        send(3, 2, 0, 1);
        send(2, 1, 0, 1);
        drain();

        // Saturation / wrap
        do_reset();
`ifdef FIR_INV_SAT_EN
        send(200, 127, 1, 1);
`else
        send(200, -56, 0, 1);
`endif
        drain();
        do_reset();
        chk("rst2_x_out", bus_if.x_out, 0);
        chk("rst2_err", bus_if.err, 0);

        // Backpressure
        bus_if.out_ready = 1'b0;
        send(7, 7, 0, 1);
        n = 0;
        while (!bus_if.out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("bp_reach_out", bus_if.out_valid, 1);
        for (int i = 0; i < 6; i++) begin
            chk("bp_out_valid", bus_if.out_valid, 1);
            chk("bp_x_out", bus_if.x_out, 7);
            chk("bp_err", bus_if.err, 0);
            chk("bp_in_ready", bus_if.in_ready, 0);
            bus_if.y_in     = 18'd99;
            bus_if.in_valid = (i % 2 == 0);
            @(negedge clk);
        end
        bus_if.in_valid  = 1'b0;
        bus_if.out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_out_valid", bus_if.out_valid, 0);
        chk("bp_release_in_ready", bus_if.in_ready, 1);
        send(14, 0, 0, 1);
        drain();

        // Reset during MAC2
        do_reset();
        send(77, 0, 0, 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_in_ready", bus_if.in_ready, 1);
        chk("midrst_out_valid", bus_if.out_valid, 0);
        send(5, 5, 0, 1);
        drain();

        // Throughput: y from fir_4 over a fixed sample sequence
        do_reset();
        for (int i = 0; i < 20; i++) begin
            xs[i] = ((i * 37) % 29) - 14;
            ys[i] = xs[i];
            if (i >= 1) ys[i] += 2 * xs[i-1];
            if (i >= 2) ys[i] -= 3 * xs[i-2];
            if (i >= 3) ys[i] += 4 * xs[i-3];
        end
        rx0 = rx;
        for (int i = 0; i < 20; i++) begin
            send(ys[i], xs[i], 0, 1);
            if (i > 0) chk("tput_period", gap, 5);
        end
        drain();
        chk("tput_count", rx - rx0, 20);

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
